// File: rtl/mul_share_arbiter_if.sv
// Bundles the client-facing request/ack bus and the multiplier-facing start/operand bus of the shared multiplier.
// Latency: none; this file only declares wires.
// Backpressure: clients hold req until their ack; the multiplier stalls the arbiter by holding mul_ready low.
// Ports: req/a_flat/b_flat in, ack/ack_err/result/grant_id/busy out (client side);
//        mul_start/mul_multiplicand/mul_multiplier out, mul_product/mul_ready in (multiplier side).
// The master modport is the arbiter; the slave modport is the surrounding clients plus the multiplier.
interface mul_share_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = 2,
  parameter int W   = 16
);
  logic [N-1:0]   req;
  logic [N*W-1:0] a_flat;
  logic [N*W-1:0] b_flat;
  logic [N-1:0]   ack;
  logic           ack_err;
  logic [2*W-1:0] result;
  logic [IDW-1:0] grant_id;
  logic           busy;
  logic           mul_start;
  logic [W-1:0]   mul_multiplicand;
  logic [W-1:0]   mul_multiplier;
  logic [2*W-1:0] mul_product;
  logic           mul_ready;

  modport master (
    input  req, a_flat, b_flat, mul_product, mul_ready,
    output ack, ack_err, result, grant_id, busy,
           mul_start, mul_multiplicand, mul_multiplier
  );

  modport slave (
    output req, a_flat, b_flat, mul_product, mul_ready,
    input  ack, ack_err, result, grant_id, busy,
           mul_start, mul_multiplicand, mul_multiplier
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one start/ready multiplier among N requesters, with a watchdog abort.
// Latency: grant edge -> mul_start next cycle; ack one cycle after the edge capturing the product.
// Backpressure: requesters hold req until ack; no grant while mul_ready is low.
// Ports: clk, rst (async, active high); bus (master modport) carries
//   req/a_flat/b_flat in, ack/ack_err/result/grant_id/busy out,
//   mul_start/mul_multiplicand/mul_multiplier out, mul_product/mul_ready in.
module mul_share_arbiter #(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int W       = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  mul_share_arbiter_if.master bus
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]     state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gid;
  logic [W-1:0]   opa;
  logic [W-1:0]   opb;
  logic [2*W-1:0] res;
  logic [WDW-1:0] wdog;
  logic           abort;

  logic           found;
  logic [IDW-1:0] pick;
  int             idx;

  // Search starts one past the last served requester so every waiting
  // requester is reached within N-1 jobs.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      ptr   <= IDW'(N - 1);
      gid   <= '0;
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      wdog  <= '0;
      abort <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // mul_ready gates the grant: after a reset mid-job the multiplier
          // may still be finishing the abandoned product.
          if (found && bus.mul_ready) begin
            gid   <= pick;
            opa   <= bus.a_flat[int'(pick)*W +: W];
            opb   <= bus.b_flat[int'(pick)*W +: W];
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wdog  <= '0;
          abort <= 1'b0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // wdog==0 marks the first WAIT cycle, where mul_ready is still the
          // stale idle level from before the start pulse.
          if (wdog != '0 && bus.mul_ready) begin
            res   <= bus.mul_product;
            state <= S_DONE;
          end else if (wdog == WDW'(TIMEOUT - 1)) begin
            res   <= '0;
            abort <= 1'b1;
            state <= S_DONE;
          end else begin
            wdog <= wdog + WDW'(1);
          end
        end
        S_DONE: begin
          ptr   <= gid;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ack              = (state == S_DONE) ? ({{(N-1){1'b0}}, 1'b1} << gid) : '0;
  assign bus.ack_err          = (state == S_DONE) && abort;
  assign bus.result           = res;
  assign bus.grant_id         = gid;
  assign bus.busy             = (state != S_IDLE);
  assign bus.mul_start        = (state == S_ISSUE);
  assign bus.mul_multiplicand = opa;
  assign bus.mul_multiplier   = opb;

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one shift-add multiplier (16x16 -> 32, start/ready handshake) among N requesters.
- Round-robin grant; latches the winner's operands, pulses the multiplier's start, waits for ready and returns the product with a one-cycle ack.
- Watchdog aborts a job if the multiplier never returns ready.
- Sits between the client blocks and the multiplier instance, and is the only driver of the multiplier's start and operand inputs.

Parameters:
- N, 4, number of requesters.
- IDW, 2, requester index width (clog2(N)).
- W, 16, operand width; product is 2*W.
- TIMEOUT, 64, maximum WAIT cycles before abort (must exceed multiplier latency).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N  per-requester request; held with operands until own ack.
- a_flat  in  N*W  multiplicands, requester i at [i*W +: W].
- b_flat  in  N*W  multipliers, requester i at [i*W +: W].
- ack  out  N  one-hot, one-cycle pulse to the served requester.
- ack_err  out  1  pulses with ack when job aborted by timeout.
- result  out  2W  product of last completed job; held until next completion.
- grant_id  out  IDW  index of requester being served (valid while busy).
- busy  out  1  high in ISSUE/WAIT/DONE.
- mul_start  out  1  one-cycle start pulse to multiplier.
- mul_multiplicand  out  W  latched operand a.
- mul_multiplier  out  W  latched operand b.
- mul_product  in  2W  multiplier product.
- mul_ready  in  1  multiplier idle/product valid; low from cycle after start until done.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; ack=0, ack_err=0, mul_start=0, busy=0, result=0, grant_id=0.
  - Operand registers cleared; rr pointer=N-1, so requester 0 has first priority.
- States:
  - IDLE: if any req and mul_ready=1, pick the first set req searching from pointer+1 with wrap (N-1 -> 0). Latch its a/b into operand regs, set grant_id, go to ISSUE. If mul_ready=0 (multiplier still busy after a controller reset), stay in IDLE.
  - ISSUE: mul_start=1 for exactly this cycle. Watchdog cleared. Go to WAIT.
  - WAIT: mul_ready ignored in the first WAIT cycle (multiplier drops it there). From the second cycle on, mul_ready=1 captures mul_product into result and goes to DONE. Watchdog increments each WAIT cycle; on reaching TIMEOUT with no ready, set result=0, flag abort, go to DONE.
  - DONE: ack[grant_id]=1 and ack_err=abort for one cycle. Pointer<=grant_id. Go to IDLE.
- Latency: req sampled high in IDLE at edge k gives mul_start during cycle k+1. ack comes one cycle after the edge on which ready is captured.
- Minimum turnaround between jobs is 1 IDLE cycle.
- Operands are taken only at grant; requester changes after grant are ignored.
- A requester must drop req on the edge sampling its ack. A req still high in IDLE is a new job.
- Simultaneous requests: exactly one granted per job. Others wait and are never starved; maximum wait is N-1 jobs.
- req dropping while granted does not cancel the job; ack still pulses.
- mul_product is not sampled outside the WAIT capture cycle.
- Reset mid-job: abandons it with no ack. The multiplier may still be busy, so IDLE gates grant on mul_ready.

Test Plan:
- Single job: req[0] with a=4, b=12 → one mul_start pulse; after model ready, result=48 (0x30), ack=0001 for one cycle, ack_err=0.
- Contention: req=1111 simultaneously, operands i*3 and i+1 → acks in order 0,1,2,3; results 0,6,18,36; one job per mul_start; mul_start never high while busy.
- Round-robin fairness: after serving 2, req=0101 held → order 0 then 2, not 2 first. Max operands 0xFFFF×0xFFFF → result 0xFFFE0001.
- Timeout: model never raises ready → after TIMEOUT=64 WAIT cycles, ack pulses with ack_err=1, result=0; next job completes normally.
- Reset mid-WAIT with model still busy 10 more cycles → outputs cleared immediately, no ack; next grant only after mul_ready=1, and requester 0 is served first.
